// File: rtl/garo_entropy_collector_if.sv
// Word delivery port between the entropy collector and the SHA3 conditioner.
// Valid/ready handshake; a transfer happens on word_valid & word_ready.
interface garo_entropy_collector_if #(
    parameter int unsigned WORD_W = 64
) ();
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_out, output word_valid, input word_ready);
    modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/garo_entropy_collector.sv
// GaRO4 entropy consumer: synchronizes raw bits, von Neumann debiases them,
// runs a repetition-count health test and packs bits into double-buffered words.
module garo_entropy_collector #(
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned WARMUP_CYC = 256,
    parameter int unsigned RCT_CUTOFF = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    output logic                          osc_en,
    input  logic                          entropy_in,
    garo_entropy_collector_if.master      wbus,
    output logic                          health_fail,
    input  logic                          clear_fail
);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned WC_W  = 16;
    localparam int unsigned RC_W  = 8;

    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, FAIL} state_t;

    state_t            state;
    logic              sync1;
    logic              smp;
    logic              prev_smp;
    logic              phase;
    logic              pair_a;
    logic              rc_armed;
    logic [WC_W-1:0]   warm_cnt;
    logic [RC_W-1:0]   rc;
    logic [CNT_W-1:0]  fill;
    logic [WORD_W-1:0] shreg;

    logic              accept;
    logic              buf_free;
    logic              vn_v;
    logic              take;
    logic              xfer;
    logic              rct_fail;
    logic [WORD_W-1:0] shreg_nx;
    logic [CNT_W-1:0]  fill_nx;

    // Debias, pack and decide whether the shift register moves to the output buffer.
    always_comb begin
        accept   = wbus.word_valid & wbus.word_ready;
        buf_free = ~wbus.word_valid | accept;
        vn_v     = (state == COLLECT) && phase && (pair_a != smp);
        take     = vn_v && (fill != CNT_W'(WORD_W));
        shreg_nx = take ? {pair_a, shreg[WORD_W-1:1]} : shreg;
        fill_nx  = fill + CNT_W'(take);
        xfer     = (state == COLLECT) && (fill_nx == CNT_W'(WORD_W)) && buf_free;
        rct_fail = (state == COLLECT) && (rc == RC_W'(RCT_CUTOFF));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            osc_en          <= 1'b0;
            health_fail     <= 1'b0;
            wbus.word_out   <= '0;
            wbus.word_valid <= 1'b0;
            sync1           <= 1'b0;
            smp             <= 1'b0;
            prev_smp        <= 1'b0;
            phase           <= 1'b0;
            pair_a          <= 1'b0;
            rc_armed        <= 1'b0;
            warm_cnt        <= '0;
            rc              <= '0;
            fill            <= '0;
            shreg           <= '0;
        end else begin
            sync1 <= entropy_in;
            smp   <= sync1;

            if (xfer) begin
                wbus.word_out   <= shreg_nx;
                wbus.word_valid <= 1'b1;
            end else if (accept) begin
                wbus.word_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= WARMUP;
                        osc_en   <= 1'b1;
                        warm_cnt <= '0;
                    end
                end
                WARMUP: begin
                    if (!en) begin
                        state  <= IDLE;
                        osc_en <= 1'b0;
                    end else if (warm_cnt == WC_W'(WARMUP_CYC - 1)) begin
                        state    <= COLLECT;
                        phase    <= 1'b0;
                        rc       <= RC_W'(1);
                        rc_armed <= 1'b0;
                        fill     <= '0;
                        shreg    <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WC_W'(1);
                    end
                end
                COLLECT: begin
                    phase    <= ~phase;
                    prev_smp <= smp;
                    rc_armed <= 1'b1;
                    if (!phase) pair_a <= smp;
                    // First sample after entry has no predecessor and keeps rc at 1.
                    if (rc_armed && (smp == prev_smp)) begin
                        if (rc != RC_W'(RCT_CUTOFF)) rc <= rc + RC_W'(1);
                    end else begin
                        rc <= RC_W'(1);
                    end
                    shreg <= shreg_nx;
                    fill  <= xfer ? '0 : fill_nx;

                    if (rct_fail) begin
                        state           <= FAIL;
                        osc_en          <= 1'b0;
                        health_fail     <= 1'b1;
                        wbus.word_valid <= 1'b0;
                        wbus.word_out   <= '0;
                        shreg           <= '0;
                        fill            <= '0;
                        phase           <= 1'b0;
                        rc              <= '0;
                    end else if (!en) begin
                        state  <= IDLE;
                        osc_en <= 1'b0;
                        shreg  <= '0;
                        fill   <= '0;
                        phase  <= 1'b0;
                        rc     <= '0;
                    end
                end
                FAIL: begin
                    if (clear_fail) begin
                        state       <= IDLE;
                        health_fail <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_garo_entropy_collector.sv
// Self-checking bench for garo_entropy_collector (WORD_W=8, WARMUP_CYC=4, RCT_CUTOFF=8).
module tb_garo_entropy_collector;
    localparam int WARMUP = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic osc_en;
    logic entropy_in;
    logic health_fail;
    logic clear_fail;

    garo_entropy_collector_if #(.WORD_W(8)) bus ();

    garo_entropy_collector #(.WORD_W(8), .WARMUP_CYC(4), .RCT_CUTOFF(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .osc_en(osc_en),
        .entropy_in(entropy_in), .wbus(bus.master),
        .health_fail(health_fail), .clear_fail(clear_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      raw;
        logic [7:0] exp;
        int         edge_v;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] q[$];
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // raw[j] is the j-th COLLECT sample; outside the string, a 0011 filler gives only discarded pairs.
    function automatic logic raw_bit(input string r, input int j);
        int f;
        if (j >= 0 && j < r.len()) return (r[j] == 8'h31);
        f = (j < 0) ? 0 : (j - r.len());
        return (f % 4) >= 2;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; en = 1'b0; bus.word_ready = 1'b0; clear_fail = 1'b0; entropy_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_osc_en", 64'(osc_en), 0);
        chk("rst_word_valid", 64'(bus.word_valid), 0);
        chk("rst_word_out", 64'(bus.word_out), 0);
        chk("rst_health_fail", 64'(health_fail), 0);
        reset_n = 1'b1;
    endtask

    // Enable at edge 0, stream raw bits, compare every valid word against the scoreboard head.
    task automatic run(input string raw, input int n_edges, input int ready_from,
                       input int en_off_at, output int first_v, output int nvalid);
        first_v = -1;
        nvalid  = 0;
        @(negedge clk);
        en = 1'b1;
        entropy_in = raw_bit(raw, -3);
        bus.word_ready = (-1 >= ready_from);
        for (int k = 0; k < n_edges; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) chk("osc_en_after_en", 64'(osc_en), 1);
            if (k == en_off_at + 1) chk("osc_en_after_en_off", 64'(osc_en), 0);
            if (k == en_off_at) en = 1'b0;
            entropy_in = raw_bit(raw, k - (WARMUP - 2));
            bus.word_ready = (k >= ready_from);
            if (bus.word_valid) begin
                nvalid++;
                if (first_v < 0) first_v = k;
                if (q.size() == 0) chk("unexpected_word", 64'(bus.word_out), 64'hDEAD);
                else chk("word_out", 64'(bus.word_out), 64'(q[0]));
                if (bus.word_ready && q.size() > 0) void'(q.pop_front());
            end
        end
    endtask

    int fv, nv;

    initial begin
        reset_n = 1'b0; en = 1'b0; entropy_in = 1'b0; clear_fail = 1'b0; bus.word_ready = 1'b0;

        vecs[0] = '{"0110010110100110", 8'hB2, 20};
        vecs[1] = '{"01100011010110100110", 8'hB2, 24};
        vecs[2] = '{"1010101010101010", 8'hFF, 20};
        vecs[3] = '{"0101010101010101", 8'h00, 20};
        vecs[4] = '{"11101000010110010110", 8'h93, 24};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            q.push_back(vecs[i].exp);
            run(vecs[i].raw, 30, 0, 1000, fv, nv);
            chk($sformatf("vec%0d_first_valid", i), 64'(fv), 64'(vecs[i].edge_v));
            chk($sformatf("vec%0d_valid_cycles", i), 64'(nv), 1);
        end

        // Backpressure: first word held, second parked in the shift register, third dropped.
        do_reset();
        q.push_back(8'hB2);
        q.push_back(8'hFF);
        run({"0110010110100110", "1010101010101010", "0101010101010101"}, 70, 60, 1000, fv, nv);
        chk("bp_first_valid", 64'(fv), 20);
        chk("bp_valid_cycles", 64'(nv), 42);
        chk("bp_queue_drained", 64'(q.size()), 0);

        // Repetition-count failure with a word pending.
        do_reset();
        q.push_back(8'hB2);
        run({"0110010110100110", "11111111111111111111"}, 29, 1000, 1000, fv, nv);
        chk("rct_pre_health_fail", 64'(health_fail), 0);
        chk("rct_pre_word_valid", 64'(bus.word_valid), 1);
        @(posedge clk); @(negedge clk);
        chk("rct_health_fail", 64'(health_fail), 1);
        chk("rct_osc_en", 64'(osc_en), 0);
        chk("rct_word_valid", 64'(bus.word_valid), 0);
        q.delete();
        repeat (3) @(negedge clk);
        chk("rct_sticky", 64'(health_fail), 1);
        clear_fail = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_fail = 1'b0;
        chk("clr_health_fail", 64'(health_fail), 0);
        chk("clr_osc_en_idle", 64'(osc_en), 0);
        @(posedge clk); @(negedge clk);
        chk("clr_warmup_restart", 64'(osc_en), 1);

        // Disable mid-word with a pending word, then re-enable from fresh bits.
        do_reset();
        q.push_back(8'hB2);
        run({"0110010110100110", "1010101010"}, 34, 1000, 32, fv, nv);
        chk("dis_word_valid_kept", 64'(bus.word_valid), 1);
        chk("dis_word_out_kept", 64'(bus.word_out), 64'hB2);
        bus.word_ready = 1'b1;
        if (bus.word_valid && q.size() > 0) void'(q.pop_front());
        @(posedge clk); @(negedge clk);
        bus.word_ready = 1'b0;
        chk("dis_accepted", 64'(bus.word_valid), 0);
        q.push_back(8'h00);
        run("0101010101010101", 24, 0, 1000, fv, nv);
        chk("reen_first_valid", 64'(fv), 20);
        chk("reen_valid_cycles", 64'(nv), 1);

        // Asynchronous reset mid-COLLECT with a held word.
        do_reset();
        q.push_back(8'hB2);
        run("0110010110100110", 24, 1000, 1000, fv, nv);
        @(posedge clk);
        #2;
        chk("arst_pre_valid", 64'(bus.word_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_osc_en", 64'(osc_en), 0);
        chk("arst_word_valid", 64'(bus.word_valid), 0);
        chk("arst_word_out", 64'(bus.word_out), 0);
        chk("arst_health_fail", 64'(health_fail), 0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        en = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
